inst_encoder: RTL and testbench
===============================

# inst_encoder

Sequential RV32-subset instruction encoder: accepts decoded fields (opcode, func7, func3, register indices, immediate) over a valid/ready handshake, packs them into 32-bit R/I/S/B-format instruction words and buffers them in a small FIFO toward a valid/ready consumer. It is the inverse of the core's field decoder. Self-test program generators and the instruction-memory preload path use it to produce words the core decodes back into identical fields.

## Interface
- DATA_WIDTH, 32: instruction word width; fixed at 32.
- FIFO_DEPTH, 4: output buffer entries; power of two, at least 2.
- CNT_WIDTH, 16: width of the emitted-instruction counter.

- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  field bundle valid.
- o_ready  output  1  encoder can accept a bundle.
- i_opcode  input  7  opcode.
- i_func7  input  7  funct7; used for R-type only.
- i_func3  input  3  funct3; used for R/I/S/B.
- i_rs1  input  5  source-1 index (integer or FP).
- i_rs2  input  5  source-2 index (R/S/B).
- i_rd  input  5  destination index (R/I).
- i_imm  input  13  signed immediate; I/S use [11:0], B uses [12:0].
- o_valid  output  1  FIFO head valid.
- i_ready  input  1  consumer takes head.
- o_inst  output  DATA_WIDTH  FIFO head word; 0 when empty.
- o_illegal  output  1  one-cycle pulse: last accepted bundle was rejected.
- o_enc_cnt  output  CNT_WIDTH  count of words popped by the consumer.

## Operation
- Accept: i_valid && o_ready at a rising edge. o_ready = !full. No same-cycle push-on-pop bypass when full.
- Format by opcode:
  - R, 0110011 / 1010011: {func7, rs2, rs1, func3, rd, opcode}.
  - I, 0010011 / 0000011 / 0000111: {imm[11:0], rs1, func3, rd, opcode}.
  - S, 0100011 / 0100111: {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
  - B, 1100011: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
- Unused input fields are ignored and do not affect the word.
- Illegal: any other opcode, or B-type with imm[0]=1. The bundle is accepted and consumed, but nothing is pushed. o_illegal is 1 for exactly the cycle after acceptance.
- FIFO: circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits that wrap modulo depth, plus an occupancy count of log2(FIFO_DEPTH)+1 bits.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
- Pop: o_valid && i_ready. o_valid = !empty. o_inst = mem[rd_ptr] when non-empty, else 0.
- Simultaneous legal push and pop: both happen and the count is unchanged. Ordering is strictly FIFO.
- o_enc_cnt increments on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- Two-state controller per entry path, IDLE/HAVE (empty vs non-empty), derived from the count; no other FSM.

## Timing
- Latency: a word accepted at edge N is visible on o_valid/o_inst after edge N (cycle N+1), when the FIFO was empty.
- Throughput: one accept and one pop per cycle.
- o_ready drops the cycle after the push that fills the FIFO. It rises the cycle after the first pop from full.
- Reset (i_rst=1 at an edge) returns:
  - o_valid=0, o_ready=1, o_inst=0, o_illegal=0, o_enc_cnt=0, both pointers 0.
  - Reset takes priority over a simultaneous push or pop. Buffered words are discarded mid-operation.
- Inputs are sampled only on an accept edge. Changes while o_ready=0 have no effect.
- o_inst and o_valid stay stable while o_valid && !i_ready.

## Configuration
- INST_ENC_FP_EN defined: FP opcodes 1010011 (R), 0000111 (I, flw) and 0100111 (S, fsw) encode as listed above.
- INST_ENC_FP_EN undefined: those three opcodes are illegal (o_illegal pulse, no push). Integer encoding is unchanged.

## Test plan
- Encode add, then a single pop. Input: opcode=0110011, func7=0, func3=0, rs1=2, rs2=3, rd=1. Required: o_inst=0x003100B3, o_valid high the cycle after accept, o_enc_cnt=1 after the pop.
- Encode the I-type addi x5,x0,-1 (opcode 0010011, rd=5, func3=0, rs1=0, imm=0xFFF). Required: o_inst=0xFFF00293.
- Encode the B-type beq x1,x2,+8 (opcode 1100011, imm=8). Required: o_inst=0x00208463. The same bundle with imm=9 gives an o_illegal pulse and FIFO count 0.
- Push 5 bundles with i_ready=0 (FIFO_DEPTH=4). Required: o_ready=0 after the 4th accept and the 5th is held. Then hold i_ready=1: the five words pop in order and o_enc_cnt ends at 5.
- Run concurrent push and pop at full rate for 100 cycles. Required: count stays constant, no loss or duplication, and o_enc_cnt=100 with pointers wrapped.
- Assert i_rst with 3 words buffered. Required: o_valid=0, o_inst=0, o_enc_cnt=0 next cycle. Also check opcode 0100111: it encodes with INST_ENC_FP_EN defined and pulses o_illegal without it.

Source files
------------

// File: rtl/inst_encoder.sv
// ============================================================================
// Module  : inst_encoder
// Brief   : Packs decoded RV32 fields into R/I/S/B instruction words and
//           buffers them in a small FIFO toward a valid/ready consumer.
//           Define INST_ENC_FP_EN to accept the FP opcodes (OP-FP, FLW, FSW).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [6:0]            i_opcode,
    input  logic [6:0]            i_func7,
    input  logic [2:0]            i_func3,
    input  logic [4:0]            i_rs1,
    input  logic [4:0]            i_rs2,
    input  logic [4:0]            i_rd,
    input  logic [12:0]           i_imm,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic                  o_illegal,
    output logic [CNT_WIDTH-1:0]  o_enc_cnt
);

    localparam int               c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_FP   = 7'b1010011;
    localparam logic [6:0] c_OP_IMM  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD = 7'b0000011;
    localparam logic [6:0] c_OP_FLW  = 7'b0000111;
    localparam logic [6:0] c_OP_ST   = 7'b0100011;
    localparam logic [6:0] c_OP_FSW  = 7'b0100111;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;

`ifdef INST_ENC_FP_EN
    localparam logic c_FP_EN = 1'b1;
`else
    localparam logic c_FP_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HAVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W:0]        count_q, count_d;
    logic [CNT_WIDTH-1:0]    enc_cnt_q, enc_cnt_d;
    logic                    illegal_q, illegal_d;

    logic [DATA_WIDTH-1:0]   w_word;
    logic                    w_legal;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;

    // Field packing; fields a format does not use never reach the word.
    always_comb begin
        w_word  = '0;
        w_legal = 1'b0;
        case (i_opcode)
            c_OP_R, c_OP_FP: begin
                w_legal = (i_opcode == c_OP_R) || c_FP_EN;
                w_word  = {i_func7, i_rs2, i_rs1, i_func3, i_rd, i_opcode};
            end
            c_OP_IMM, c_OP_LOAD, c_OP_FLW: begin
                w_legal = (i_opcode != c_OP_FLW) || c_FP_EN;
                w_word  = {i_imm[11:0], i_rs1, i_func3, i_rd, i_opcode};
            end
            c_OP_ST, c_OP_FSW: begin
                w_legal = (i_opcode == c_OP_ST) || c_FP_EN;
                w_word  = {i_imm[11:5], i_rs2, i_rs1, i_func3, i_imm[4:0], i_opcode};
            end
            c_OP_BR: begin
                // Branch offsets are halfword aligned; an odd offset is unencodable.
                w_legal = !i_imm[0];
                w_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_func3,
                           i_imm[4:1], i_imm[11], i_opcode};
            end
            default: begin
                w_legal = 1'b0;
                w_word  = '0;
            end
        endcase
    end

    assign w_empty  = (state_q == IDLE);
    assign w_full   = (count_q == c_FULL);
    assign w_accept = i_valid && !w_full;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = !w_empty && i_ready;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        enc_cnt_d = enc_cnt_q;
        illegal_d = w_accept && !w_legal;
        if (w_push) begin
            mem_d[wr_ptr_q] = w_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            enc_cnt_d = enc_cnt_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        state_d = (count_d != '0) ? HAVE : IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            enc_cnt_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            enc_cnt_q <= enc_cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_ready   = !w_full;
    assign o_valid   = !w_empty;
    assign o_inst    = w_empty ? '0 : mem_q[rd_ptr_q];
    assign o_illegal = illegal_q;
    assign o_enc_cnt = enc_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
// Module  : tb_inst_encoder
// Brief   : Directed self-checking bench for inst_encoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_encoder;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [6:0]  i_opcode;
    logic [6:0]  i_func7;
    logic [2:0]  i_func3;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [4:0]  i_rd;
    logic [12:0] i_imm;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic        o_illegal;
    logic [15:0] o_enc_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    inst_encoder #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (16)
    ) u_dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_opcode (i_opcode),
        .i_func7  (i_func7),
        .i_func3  (i_func3),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_rd     (i_rd),
        .i_imm    (i_imm),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_inst   (o_inst),
        .o_illegal(o_illegal),
        .o_enc_cnt(o_enc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [12:0] imm);
        i_opcode = op;
        i_func7  = f7;
        i_func3  = f3;
        i_rs1    = rs1;
        i_rs2    = rs2;
        i_rd     = rd;
        i_imm    = imm;
    endtask

    // Present a bundle and hold it until it is accepted (bounded wait).
    task automatic send(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [12:0] imm);
        int waited;
        set_fields(op, f7, f3, rs1, rs2, rd, imm);
        i_valid = 1'b1;
        waited  = 0;
        while (!o_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check_eq("accept_timeout", 32'd0, 32'd1);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic pop_one();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    function automatic logic [31:0] addi_word(input logic [11:0] imm, input logic [4:0] rd);
        return {imm, 5'd0, 3'd0, rd, 7'b0010011};
    endfunction

    logic [31:0] exp_q[$];
    logic [31:0] five_words [5];
    int          n_popped;
    logic        acc_now;
    logic        pop_now;
    logic        stream_ok;

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        set_fields(7'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0);
        five_words = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};
        do_reset();

        check_eq("rst_valid",   {31'd0, o_valid},   32'd0);
        check_eq("rst_ready",   {31'd0, o_ready},   32'd1);
        check_eq("rst_inst",    o_inst,             32'd0);
        check_eq("rst_illegal", {31'd0, o_illegal}, 32'd0);
        check_eq("rst_cnt",     {16'd0, o_enc_cnt}, 32'd0);

        // add x1,x2,x3 with junk in the unused immediate
        send(7'b0110011, 7'd0, 3'd0, 5'd2, 5'd3, 5'd1, 13'h1ABC);
        check_eq("add_valid", {31'd0, o_valid}, 32'd1);
        check_eq("add_inst",  o_inst,           32'h003100B3);
        pop_one();
        check_eq("add_cnt",        {16'd0, o_enc_cnt}, 32'd1);
        check_eq("add_empty_inst", o_inst,             32'd0);

        // addi x5,x0,-1 with junk in func7/rs2
        send(7'b0010011, 7'h55, 3'd0, 5'd0, 5'd17, 5'd5, 13'h0FFF);
        check_eq("addi_inst", o_inst, 32'hFFF00293);
        pop_one();

        send(7'b1100011, 7'h7F, 3'd0, 5'd1, 5'd2, 5'd9, 13'd8);
        check_eq("beq_inst", o_inst, 32'h00208463);
        check_eq("beq_no_illegal", {31'd0, o_illegal}, 32'd0);
        pop_one();

        send(7'b1100011, 7'd0, 3'd0, 5'd1, 5'd2, 5'd0, 13'd9);
        check_eq("beq_odd_illegal", {31'd0, o_illegal}, 32'd1);
        check_eq("beq_odd_valid",   {31'd0, o_valid},   32'd0);
        tick();
        check_eq("illegal_one_cycle", {31'd0, o_illegal}, 32'd0);

        send(7'b1111111, 7'd0, 3'd0, 5'd1, 5'd2, 5'd3, 13'd0);
        check_eq("bad_op_illegal", {31'd0, o_illegal}, 32'd1);
        check_eq("bad_op_valid",   {31'd0, o_valid},   32'd0);

        // beq x1,x2,-4 ; lw x5,-4(x2) ; sw x3,4(x2) queued, then drained in order
        send(7'b1100011, 7'd0, 3'd0, 5'd1, 5'd2, 5'd0, 13'h1FFC);
        send(7'b0000011, 7'd0, 3'd2, 5'd2, 5'd0, 5'd5, 13'h1FFC);
        send(7'b0100011, 7'd0, 3'd2, 5'd2, 5'd3, 5'd0, 13'd4);
        check_eq("beq_neg_inst", o_inst, 32'hFE208EE3);
        pop_one();
        check_eq("lw_inst", o_inst, 32'hFFC12283);
        pop_one();
        check_eq("sw_inst", o_inst, 32'h00312223);
        pop_one();
        check_eq("cnt_after_six", {16'd0, o_enc_cnt}, 32'd6);

        // Fill to full with consumer stalled; fifth bundle must wait
        do_reset();
        for (int k = 0; k < 4; k++)
            send(7'b0010011, 7'd0, 3'd0, 5'd0, 5'd0, 5'(k + 1), 13'(k + 1));
        check_eq("full_ready", {31'd0, o_ready}, 32'd0);
        set_fields(7'b0010011, 7'd0, 3'd0, 5'd0, 5'd0, 5'd5, 13'd5);
        i_valid = 1'b1;
        tick();
        tick();
        check_eq("full_still_blocked", {31'd0, o_ready}, 32'd0);
        check_eq("stall_head_stable",  o_inst,           five_words[0]);
        i_ready  = 1'b1;
        n_popped = 0;
        for (int c = 0; c < 20 && n_popped < 5; c++) begin
            acc_now = i_valid && o_ready;
            pop_now = o_valid && i_ready;
            if (pop_now) begin
                check_eq($sformatf("drain_word%0d", n_popped), o_inst, five_words[n_popped]);
                n_popped++;
            end
            tick();
            if (acc_now) i_valid = 1'b0;
        end
        i_ready = 1'b0;
        i_valid = 1'b0;
        check_eq("drain_count", n_popped,            32'd5);
        check_eq("drain_cnt",   {16'd0, o_enc_cnt},  32'd5);
        check_eq("drain_empty", {31'd0, o_valid},    32'd0);

        // 100 cycles of simultaneous push and pop with one word resident
        do_reset();
        exp_q.delete();
        send(7'b0010011, 7'd0, 3'd0, 5'd0, 5'd0, 5'd31, 13'd0);
        exp_q.push_back(addi_word(12'd0, 5'd31));
        i_ready   = 1'b1;
        i_valid   = 1'b1;
        stream_ok = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            set_fields(7'b0010011, 7'd0, 3'd0, 5'd0, 5'd0, 5'(c), 13'(c * 37));
            exp_q.push_back(addi_word(12'(c * 37), 5'(c)));
            if (!(o_valid && o_ready)) stream_ok = 1'b0;
            if (o_inst !== exp_q[0]) begin
                check_eq($sformatf("stream_word%0d", c), o_inst, exp_q[0]);
                stream_ok = 1'b0;
            end
            void'(exp_q.pop_front());
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check_eq("stream_ok",   {31'd0, stream_ok}, 32'd1);
        check_eq("stream_cnt",  {16'd0, o_enc_cnt}, 32'd100);
        check_eq("stream_left", o_inst,             exp_q[0]);
        tick();
        check_eq("stream_one_left", {31'd0, o_valid}, 32'd1);

        // Reset wins over a simultaneous push and pop with three words buffered
        send(7'b0110011, 7'd0, 3'd0, 5'd2, 5'd3, 5'd1, 13'd0);
        send(7'b0110011, 7'd0, 3'd0, 5'd2, 5'd3, 5'd1, 13'd0);
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        check_eq("mid_rst_valid", {31'd0, o_valid},   32'd0);
        check_eq("mid_rst_inst",  o_inst,             32'd0);
        check_eq("mid_rst_cnt",   {16'd0, o_enc_cnt}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, o_ready},   32'd1);

        // fsw f3,4(x2): legal only when FP support is built in
        send(7'b0100111, 7'd0, 3'd2, 5'd2, 5'd3, 5'd0, 13'd4);
`ifdef INST_ENC_FP_EN
        check_eq("fsw_illegal", {31'd0, o_illegal}, 32'd0);
        check_eq("fsw_inst",    o_inst,             32'h00312227);
`else
        check_eq("fsw_illegal", {31'd0, o_illegal}, 32'd1);
        check_eq("fsw_valid",   {31'd0, o_valid},   32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
